// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM-style DDR port among NUM_PORTS requesters.
// One transaction in flight at a time; a watchdog turns a hung transaction into an error completion.
module mem_port_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_PORTS-1:0]    i_up_req,
    input  logic [NUM_PORTS-1:0]    i_up_we,
    input  logic [4*NUM_PORTS-1:0]  i_up_be,
    input  logic [27*NUM_PORTS-1:0] i_up_addr,
    input  logic [32*NUM_PORTS-1:0] i_up_wdata,
    output logic [31:0]             o_up_rdata,
    output logic [NUM_PORTS-1:0]    o_up_ready,
    output logic [NUM_PORTS-1:0]    o_up_err,
    output logic [NUM_PORTS-1:0]    o_up_grant,
    output logic                    o_dn_req,
    output logic                    o_dn_we,
    output logic [3:0]              o_dn_be,
    output logic [26:0]             o_dn_addr,
    output logic [31:0]             o_dn_wdata,
    input  logic [31:0]             i_dn_rdata,
    input  logic                    i_dn_ready,
    input  logic                    i_dn_busy
);
    localparam int PW = (NUM_PORTS > 2) ? 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_gidx;
    logic [31:0]           r_wdog;

    logic                  w_any;
    logic [PW-1:0]         w_sel;
    logic [PW-1:0]         w_idx;
    logic [PW-1:0]         w_next;
    logic [NUM_PORTS-1:0]  w_onehot;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [26:0]           w_addr;
    logic [31:0]           w_wdata;
    logic                  w_timeout;

    // First requesting port at or after r_ptr, searching with wrap-around.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_PORTS);
            if (!w_any && i_up_req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_be    = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_sel == PW'(p)) begin
                w_we    = i_up_we[p];
                w_be    = i_up_be[4*p +: 4];
                w_addr  = i_up_addr[27*p +: 27];
                w_wdata = i_up_wdata[32*p +: 32];
            end
        end
    end

    assign w_onehot  = NUM_PORTS'(1) << w_sel;
    assign w_next    = (r_gidx == PW'(NUM_PORTS - 1)) ? '0 : r_gidx + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_wdog     <= '0;
            o_up_rdata <= '0;
            o_up_ready <= '0;
            o_up_err   <= '0;
            o_up_grant <= '0;
            o_dn_req   <= 1'b0;
            o_dn_we    <= 1'b0;
            o_dn_be    <= '0;
            o_dn_addr  <= '0;
            o_dn_wdata <= '0;
        end else begin
            o_dn_req   <= 1'b0;
            o_up_ready <= '0;
            o_up_err   <= '0;
            case (r_state)
                S_IDLE: begin
                    // A dn_ready seen here belongs to an abandoned transaction and is dropped.
                    if (!i_dn_busy && w_any) begin
                        r_gidx     <= w_sel;
                        o_up_grant <= w_onehot;
                        o_dn_we    <= w_we;
                        o_dn_be    <= w_be;
                        o_dn_addr  <= w_addr;
                        o_dn_wdata <= w_wdata;
                        o_dn_req   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_dn_ready) begin
                        o_up_rdata <= o_dn_we ? 32'h0 : i_dn_rdata;
                        o_up_ready <= o_up_grant;
                        o_up_grant <= '0;
                        r_ptr      <= w_next;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        o_up_rdata <= '0;
                        o_up_ready <= o_up_grant;
                        o_up_err   <= o_up_grant;
                        o_up_grant <= '0;
                        r_ptr      <= w_next;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected completions,
// a negedge monitor pops and compares them; a second instance exercises the watchdog.
module tb_mem_port_arbiter;
    localparam int NP = 3;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   w;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NP-1:0]  upReq = '0, upWe = '0;
    logic [4*NP-1:0]  upBe = '0;
    logic [27*NP-1:0] upAddr = '0;
    logic [32*NP-1:0] upWdata = '0;
    logic [31:0]    upRdata, dnWdata, dnRdata = '0;
    logic [NP-1:0]  upReady, upErr, upGrant;
    logic           dnReq, dnWe, dnReady = 1'b0, dnBusy = 1'b0;
    logic [3:0]     dnBe;
    logic [26:0]    dnAddr;

    logic [NP-1:0]  tUpReq = '0;
    logic [27*NP-1:0] tUpAddr = '0;
    logic [31:0]    tUpRdata, tDnWdata, tDnRdata = '0;
    logic [NP-1:0]  tUpReady, tUpErr, tUpGrant;
    logic           tDnReq, tDnWe, tDnReady = 1'b0;
    logic [3:0]     tDnBe;
    logic [26:0]    tDnAddr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(4096)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_up_req(upReq), .i_up_we(upWe), .i_up_be(upBe), .i_up_addr(upAddr), .i_up_wdata(upWdata),
        .o_up_rdata(upRdata), .o_up_ready(upReady), .o_up_err(upErr), .o_up_grant(upGrant),
        .o_dn_req(dnReq), .o_dn_we(dnWe), .o_dn_be(dnBe), .o_dn_addr(dnAddr), .o_dn_wdata(dnWdata),
        .i_dn_rdata(dnRdata), .i_dn_ready(dnReady), .i_dn_busy(dnBusy)
    );

    mem_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(16)) tDut (
        .i_clk(clk), .i_rst(rst),
        .i_up_req(tUpReq), .i_up_we('0), .i_up_be('1), .i_up_addr(tUpAddr), .i_up_wdata('0),
        .o_up_rdata(tUpRdata), .o_up_ready(tUpReady), .o_up_err(tUpErr), .o_up_grant(tUpGrant),
        .o_dn_req(tDnReq), .o_dn_we(tDnWe), .o_dn_be(tDnBe), .o_dn_addr(tDnAddr), .o_dn_wdata(tDnWdata),
        .i_dn_rdata(tDnRdata), .i_dn_ready(tDnReady), .i_dn_busy(1'b0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we, input logic [3:0] be,
                                 input logic [26:0] addr, input logic [31:0] wdata);
        upReq[port]             = req;
        upWe[port]              = we;
        upBe[4*port +: 4]       = be;
        upAddr[27*port +: 27]   = addr;
        upWdata[32*port +: 32]  = wdata;
    endtask

    // Plays the adapter: waits for dn_req, checks the issued fields, answers lat cycles later.
    task automatic serveTxn(input int port, input logic [31:0] rdata, input int lat, output int waited);
        waited = 0;
        while (dnReq !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("dn_req_seen", dnReq, 32'd1);
        checkOutput("grant", upGrant, 32'(1) << port);
        checkOutput("dn_addr", dnAddr, upAddr[27*port +: 27]);
        checkOutput("dn_we", dnWe, upWe[port]);
        checkOutput("dn_be", dnBe, upBe[4*port +: 4]);
        checkOutput("dn_wdata", dnWdata, upWdata[32*port +: 32]);
        @(negedge clk);
        checkOutput("dn_req_pulse", dnReq, 32'd0);
        repeat (lat - 1) @(negedge clk);
        sb.push_back('{port, upWe[port] ? 32'h0 : rdata, 1'b0});
        dnRdata = rdata;
        dnReady = 1'b1;
        @(negedge clk);
        dnReady = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && upReady !== '0) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready: got up_ready=%b, expected none at %0t", upReady, $time);
            end else begin
                e = sb.pop_front();
                checkOutput("ready_onehot", 32'($onehot(upReady)), 32'd1);
                checkOutput("up_ready", upReady, 32'(1) << e.port);
                checkOutput("up_rdata", upRdata, e.rdata);
                checkOutput("up_err", upErr, e.err ? (32'(1) << e.port) : 32'd0);
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_grant"}, upGrant, 32'd0);
        checkOutput({tag, "_dn_req"}, dnReq, 32'd0);
        checkOutput({tag, "_dn_addr"}, dnAddr, 32'd0);
        checkOutput({tag, "_dn_we"}, dnWe, 32'd0);
        checkOutput({tag, "_dn_be"}, dnBe, 32'd0);
        checkOutput({tag, "_dn_wdata"}, dnWdata, 32'd0);
        checkOutput({tag, "_up_ready"}, upReady, 32'd0);
        checkOutput({tag, "_up_err"}, upErr, 32'd0);
        checkOutput({tag, "_up_rdata"}, upRdata, 32'd0);
    endtask

    initial begin
        int n;
        logic sawReq;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        checkOutput("reset_t_ready", tUpReady, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fairness: all three ports request continuously.
        for (int p = 0; p < NP; p++) applyStimulus(p, 1'b1, 1'b0, 4'hF, 27'(256 * (p + 1)), 32'h0);
        for (int t = 0; t < 6; t++) serveTxn(t % NP, 32'hA000_0000 + 32'(t), 2, w);
        for (int p = 0; p < NP; p++) upReq[p] = 1'b0;
        repeat (2) @(negedge clk);

        // Single read with a 30-cycle adapter.
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 27'h100, 32'h0);
        serveTxn(1, 32'hDEAD_BEEF, 30, w);
        checkOutput("single_read_latency", w, 32'd1);
        upReq[1] = 1'b0;
        @(negedge clk);

        // Zero-byte-enable write answered immediately with garbage rdata.
        applyStimulus(0, 1'b1, 1'b1, 4'h0, 27'h40, 32'h1234_5678);
        serveTxn(0, 32'hFFFF_FFFF, 1, w);
        upReq[0] = 1'b0;
        checkOutput("zbe_idle_grant", upGrant, 32'd0);
        @(negedge clk);
        checkOutput("zbe_idle_dn_req", dnReq, 32'd0);

        // Busy gating.
        dnBusy = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 4'hF, 27'h300, 32'h0);
        sawReq = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dnReq) sawReq = 1'b1;
        end
        checkOutput("busy_no_dn_req", sawReq, 32'd0);
        dnBusy = 1'b0;
        @(negedge clk);
        checkOutput("busy_release_dn_req", dnReq, 32'd1);
        serveTxn(2, 32'hCAFE_0002, 3, w);
        upReq[2] = 1'b0;
        @(negedge clk);

        // Reset during WAIT with a nonzero round-robin pointer.
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 27'h44, 32'h0);
        serveTxn(0, 32'h0000_0044, 1, w);
        upReq[0] = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 27'h88, 32'h0);
        n = 0;
        while (dnReq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pre_reset_dn_req", dnReq, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        upReq[1] = 1'b0;
        rst = 1'b1;
        dnReady = 1'b1;
        @(negedge clk);
        dnReady = 1'b0;
        checkOutput("late_ready_ignored", upReady, 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 4'hF, 27'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'hF, 27'h20, 32'h0);
        serveTxn(0, 32'h1111_0000, 2, w);
        upReq[0] = 1'b0;
        serveTxn(1, 32'h2222_0000, 2, w);
        upReq[1] = 1'b0;
        applyStimulus(2, 1'b1, 1'b0, 4'hF, 27'h300, 32'h0);
        serveTxn(2, 32'h3333_0000, 2, w);
        upReq[2] = 1'b0;
        @(negedge clk);

        // Watchdog instance: adapter never answers.
        tUpReq[0] = 1'b1;
        tUpAddr[26:0] = 27'h200;
        n = 0;
        while (tDnReq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_dn_req", tDnReq, 32'd1);
        n = 0;
        while (tUpReady === '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", n, 32'd17);
        checkOutput("timeout_ready", tUpReady, 32'b001);
        checkOutput("timeout_err", tUpErr, 32'b001);
        checkOutput("timeout_rdata", tUpRdata, 32'd0);
        tUpReq[0] = 1'b0;
        tDnRdata = 32'h7777_7777;
        tDnReady = 1'b1;
        @(negedge clk);
        tDnReady = 1'b0;
        checkOutput("timeout_late_ready_a", tUpReady, 32'd0);
        @(negedge clk);
        checkOutput("timeout_late_ready_b", tUpReady, 32'd0);

        // dn_ready on the exact timeout cycle wins.
        tUpReq[1] = 1'b1;
        tUpAddr[53:27] = 27'h210;
        n = 0;
        while (tDnReq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("race_dn_req", tDnReq, 32'd1);
        checkOutput("race_grant", tUpGrant, 32'b010);
        repeat (16) @(negedge clk);
        tDnRdata = 32'h5A5A_5A5A;
        tDnReady = 1'b1;
        @(negedge clk);
        tDnReady = 1'b0;
        tUpReq[1] = 1'b0;
        checkOutput("race_ready", tUpReady, 32'b010);
        checkOutput("race_err", tUpErr, 32'd0);
        checkOutput("race_rdata", tUpRdata, 32'h5A5A_5A5A);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
